fft8_stage_sequencer: RTL and testbench

FFT8_STAGE_SEQUENCER -- requirements
Module: fft8_stage_sequencer

---
 rtl/fft8_stage_sequencer.sv | 135 +++++++++++++
 tb/tb_fft8_stage_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_stage_sequencer.sv
// Control sequencer for a three-stage radix-2 8-point FFT built on a shared MAC array.
// Steps the butterfly stages, selects the MAC source, issues twiddle indices and hands off the result frame.
module fft8_stage_sequencer #(
  parameter int MAC_LATENCY = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       In_Valid,
  output logic       In_Ready,
  input  logic       Abort,
  input  logic       Out_Ready,
  output logic       Out_Valid,
  output logic [1:0] Stage,
  output logic       Src_Sel,
  output logic       Cap_En,
  output logic [1:0] W8_0_Index,
  output logic [1:0] W8_1_Index,
  output logic [1:0] W8_2_Index,
  output logic [1:0] W8_3_Index,
  output logic       Busy
);

  localparam logic [3:0] LAST_CNT = 4'(MAC_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] stage_reg, stage_next;
  logic [3:0] cnt_reg, cnt_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      stage_reg <= 2'd0;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        stage_next = 2'd0;
        cnt_next   = 4'd0;
        // Abort in IDLE blocks a frame offered in the same cycle.
        if (In_Valid && !Abort) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (Abort || stage_reg == 2'd3 || cnt_reg > LAST_CNT) begin
          state_next = IDLE;
          stage_next = 2'd0;
          cnt_next   = 4'd0;
        end else if (cnt_reg < LAST_CNT) begin
          cnt_next = cnt_reg + 4'd1;
        end else if (stage_reg < 2'd2) begin
          stage_next = stage_reg + 2'd1;
          cnt_next   = 4'd0;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (Abort || Out_Ready) begin
          state_next = IDLE;
          stage_next = 2'd0;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        state_next = IDLE;
        stage_next = 2'd0;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_comb begin
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    Busy      = 1'b0;
    Cap_En    = 1'b0;
    Src_Sel   = 1'b0;
    Stage     = 2'd0;
    case (state_reg)
      IDLE: In_Ready = 1'b1;
      RUN: begin
        Busy    = 1'b1;
        Stage   = stage_reg;
        Src_Sel = (stage_reg != 2'd0);
        Cap_En  = (cnt_reg == LAST_CNT);
      end
      DONE: begin
        Busy      = 1'b1;
        Out_Valid = 1'b1;
        Stage     = 2'd2;
        Src_Sel   = 1'b1;
      end
      default: ;
    endcase
  end

  // Twiddle exponents: stage 1 alternates 0/2, stage 2 uses the MAC number itself.
  logic       run_s1, run_s2;
  logic [1:0] w8_idx [4];

  assign run_s1 = (state_reg == RUN) && (stage_reg == 2'd1);
  assign run_s2 = (state_reg == RUN) && (stage_reg == 2'd2);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_twiddle
      localparam logic [1:0] S1_K = (gi % 2 == 1) ? 2'd2 : 2'd0;
      localparam logic [1:0] S2_K = 2'(gi);
      assign w8_idx[gi] = run_s1 ? S1_K : (run_s2 ? S2_K : 2'd0);
    end
  endgenerate

  assign W8_0_Index = w8_idx[0];
  assign W8_1_Index = w8_idx[1];
  assign W8_2_Index = w8_idx[2];
  assign W8_3_Index = w8_idx[3];

endmodule

// File: tb/tb_fft8_stage_sequencer.sv
// Bench for fft8_stage_sequencer: directed scenarios on MAC_LATENCY=1 and 3 instances,
// plus random traffic checked against a cycle-count model of the frame schedule.
module tb_fft8_stage_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_src_sel, a_cap_en, a_busy;
  logic [1:0] a_stage, a_w0, a_w1, a_w2, a_w3;
  logic       b_in_ready, b_out_valid, b_src_sel, b_cap_en, b_busy;
  logic [1:0] b_stage, b_w0, b_w1, b_w2, b_w3;
  logic [14:0] a_vec, b_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft8_stage_sequencer #(.MAC_LATENCY(1)) dut_a (
    .CLK(clk), .RST(rst), .In_Valid(in_valid), .In_Ready(a_in_ready), .Abort(abort),
    .Out_Ready(out_ready), .Out_Valid(a_out_valid), .Stage(a_stage), .Src_Sel(a_src_sel),
    .Cap_En(a_cap_en), .W8_0_Index(a_w0), .W8_1_Index(a_w1), .W8_2_Index(a_w2),
    .W8_3_Index(a_w3), .Busy(a_busy)
  );

  fft8_stage_sequencer #(.MAC_LATENCY(3)) dut_b (
    .CLK(clk), .RST(rst), .In_Valid(in_valid), .In_Ready(b_in_ready), .Abort(abort),
    .Out_Ready(out_ready), .Out_Valid(b_out_valid), .Stage(b_stage), .Src_Sel(b_src_sel),
    .Cap_En(b_cap_en), .W8_0_Index(b_w0), .W8_1_Index(b_w1), .W8_2_Index(b_w2),
    .W8_3_Index(b_w3), .Busy(b_busy)
  );

  // {in_ready, out_valid, busy, cap_en, src_sel, stage, w0, w1, w2, w3}
  assign a_vec = {a_in_ready, a_out_valid, a_busy, a_cap_en, a_src_sel, a_stage, a_w0, a_w1, a_w2, a_w3};
  assign b_vec = {b_in_ready, b_out_valid, b_busy, b_cap_en, b_src_sel, b_stage, b_w0, b_w1, b_w2, b_w3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Frame model: mode 0 idle, 1 running (t = cycles since accept, 1-based), 2 result held.
  task automatic model_step(input int lat, inout int mode, inout int t);
    if (rst) begin
      mode = 0; t = 0;
    end else begin
      case (mode)
        0: if (in_valid && !abort) begin mode = 1; t = 1; end
        1: if (abort) begin mode = 0; t = 0; end
           else if (t == 3 * (lat + 1)) mode = 2;
           else t = t + 1;
        default: if (abort || out_ready) begin mode = 0; t = 0; end
      endcase
    end
  endtask

  function automatic logic [14:0] model_vec(int lat, int mode, int t);
    logic [14:0] v;
    int s;
    v = '0;
    case (mode)
      0: v[14] = 1'b1;
      1: begin
        s = (t - 1) / (lat + 1);
        v[12] = 1'b1;
        v[11] = (((t - 1) % (lat + 1)) == lat);
        v[10] = (s != 0);
        v[9:8] = 2'(s);
        v[7:0] = (s == 1) ? 8'h22 : ((s == 2) ? 8'h1B : 8'h00);
      end
      default: begin
        v[13] = 1'b1; v[12] = 1'b1; v[10] = 1'b1; v[9:8] = 2'd2;
      end
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; abort = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    total++;
    if (a_vec !== 15'h4000) begin bad++; $display("FAIL reset_a got=%h want=%h", a_vec, 15'h4000); end
    total++;
    if (b_vec !== 15'h4000) begin bad++; $display("FAIL reset_b got=%h want=%h", b_vec, 15'h4000); end
    $display("test_reset: reset edge applied");
  endtask

  task automatic test_nominal();
    logic [7:0]  wtab [3];
    logic [10:0] got, want;
    wtab[0] = 8'h00; wtab[1] = 8'h22; wtab[2] = 8'h1B;
    do_reset();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 6) begin
        got  = {a_cap_en, a_stage, a_w0, a_w1, a_w2, a_w3};
        want = {(k % 2 == 0), 2'((k - 1) / 2), wtab[(k - 1) / 2]};
        total++;
        if (got !== want) begin bad++; $display("FAIL nominal_cycle%0d got=%h want=%h", k, got, want); end
      end else begin
        total++;
        if ({a_out_valid, a_stage, a_in_ready} !== 4'b1100) begin
          bad++; $display("FAIL nominal_done%0d got=%b want=1100", k, {a_out_valid, a_stage, a_in_ready});
        end
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if ({a_in_ready, a_out_valid, a_busy} !== 3'b100) begin
      bad++; $display("FAIL nominal_release got=%b want=100", {a_in_ready, a_out_valid, a_busy});
    end
    $display("test_nominal: frame complete");
  endtask

  task automatic test_lat3();
    int first_ov;
    int caps [$];
    do_reset();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    first_ov = 0;
    for (int k = 1; k <= 40; k++) begin
      if (b_cap_en) caps.push_back(k);
      if (b_out_valid && first_ov == 0) first_ov = k;
      tick();
    end
    total++;
    if (first_ov !== 13) begin bad++; $display("FAIL lat3_out_valid_cycle got=%0d want=13", first_ov); end
    total++;
    if (caps.size() !== 3) begin bad++; $display("FAIL lat3_cap_count got=%0d want=3", caps.size()); end
    else begin
      total++;
      if (caps[0] !== 4 || caps[1] !== 8 || caps[2] !== 12) begin
        bad++; $display("FAIL lat3_cap_cycles got=%0d,%0d,%0d want=4,8,12", caps[0], caps[1], caps[2]);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("test_lat3: frame complete");
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1;
    tick();
    repeat (6) tick();
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({a_out_valid, a_stage, a_in_ready, a_busy} !== 5'b11001) begin
        bad++; $display("FAIL backpressure_hold%0d got=%b want=11001", k, {a_out_valid, a_stage, a_in_ready, a_busy});
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({a_in_ready, a_out_valid, a_busy} !== 3'b100) begin
      bad++; $display("FAIL backpressure_release got=%b want=100", {a_in_ready, a_out_valid, a_busy});
    end
    in_valid = 1'b0; out_ready = 1'b0;
    $display("test_backpressure: frame released");
  endtask

  task automatic test_abort();
    int ov_seen, caps;
    do_reset();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    total++;
    if ({a_cap_en, a_stage} !== 3'b101) begin bad++; $display("FAIL abort_setup got=%b want=101", {a_cap_en, a_stage}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({a_in_ready, a_busy, a_stage, a_cap_en} !== 5'b10000) begin
      bad++; $display("FAIL abort_idle got=%b want=10000", {a_in_ready, a_busy, a_stage, a_cap_en});
    end
    ov_seen = 0;
    repeat (10) begin if (a_out_valid) ov_seen = 1; tick(); end
    total++;
    if (ov_seen !== 0) begin bad++; $display("FAIL abort_no_out_valid got=%0d want=0", ov_seen); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    caps = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k <= 6 && a_cap_en) caps++;
      if (k == 7) begin
        total++;
        if ({a_out_valid, caps[1:0]} !== 3'b111) begin
          bad++; $display("FAIL abort_next_frame got=ov%0d caps%0d want=ov1 caps3", a_out_valid, caps);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("test_abort: aborted frame then full frame");
  endtask

  task automatic test_reset_midrun();
    int ov_seen;
    do_reset();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    total++;
    if ({a_stage, a_busy} !== 3'b101) begin bad++; $display("FAIL midrun_setup got=%b want=101", {a_stage, a_busy}); end
    rst = 1'b1; abort = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
    total++;
    if (a_vec !== 15'h4000) begin bad++; $display("FAIL midrun_reset_a got=%h want=%h", a_vec, 15'h4000); end
    total++;
    if (b_vec !== 15'h4000) begin bad++; $display("FAIL midrun_reset_b got=%h want=%h", b_vec, 15'h4000); end
    ov_seen = 0;
    repeat (12) begin if (a_out_valid || a_busy) ov_seen = 1; tick(); end
    total++;
    if (ov_seen !== 0) begin bad++; $display("FAIL midrun_discard got=%0d want=0", ov_seen); end
    $display("test_reset_midrun: frame discarded");
  endtask

  task automatic test_back_to_back();
    int last, n;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    last = -1; n = 0;
    for (int k = 0; k < 42; k++) begin
      if (a_in_ready) begin
        if (last >= 0) begin
          total++;
          if (k - last !== 8) begin bad++; $display("FAIL b2b_spacing got=%0d want=8", k - last); end
        end
        last = k; n++;
      end
      tick();
    end
    total++;
    if (n !== 6) begin bad++; $display("FAIL b2b_accepts got=%0d want=6", n); end
    in_valid = 1'b0; out_ready = 1'b0;
    $display("test_back_to_back: %0d accepts", n);
  endtask

  task automatic test_random();
    int ma, ta, mb, tb;
    logic [14:0] ea, eb;
    ma = 0; ta = 0; mb = 0; tb = 0;
    for (int i = 0; i < 800; i++) begin
      rst       = (i == 0) || ($urandom_range(0, 149) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      abort     = $urandom_range(0, 24) == 0;
      out_ready = $urandom_range(0, 2) == 0;
      model_step(1, ma, ta);
      model_step(3, mb, tb);
      tick();
      ea = model_vec(1, ma, ta);
      eb = model_vec(3, mb, tb);
      total++;
      if (a_vec !== ea) begin bad++; $display("FAIL random_a cycle=%0d got=%h want=%h", i, a_vec, ea); end
      total++;
      if (b_vec !== eb) begin bad++; $display("FAIL random_b cycle=%0d got=%h want=%h", i, b_vec, eb); end
    end
    rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    $display("test_random: 800 cycles");
  endtask

  initial begin
    tick();
    test_reset();
    test_nominal();
    test_lat3();
    test_backpressure();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
